// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for an approximate multiplier: recomputes the exact product,
// pipelines |exact - R| and accumulates error count, saturating ED sum and worst case.
module approx_mult_err_monitor #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 17,
  parameter int unsigned SUM_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_samples,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  input  logic [2*DATA_W-1:0]   R,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      sample_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [SUM_W-1:0]      sum_ed,
  output logic [2*DATA_W-1:0]   max_ed,
  output logic [DATA_W-1:0]     max_a,
  output logic [DATA_W-1:0]     max_b
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CntOne = 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [CNT_W-1:0]   r_num, r_cnt, r_err;
  logic [SUM_W-1:0]   r_sum;
  logic [PW-1:0]      r_max;
  logic [DATA_W-1:0]  r_max_a, r_max_b;

  logic [DATA_W-1:0]  r_a1, r_b1, r_a2, r_b2;
  logic [PW-1:0]      r_r1, r_exact1, r_ed2;
  logic               r_v1, r_v2;

  logic               w_accept, w_start, w_last;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [PW-1:0]      w_exact, w_ed;
  logic [SUM_W:0]     w_sum_ext;
  logic [SUM_W-1:0]   w_sum_sat;

  assign in_ready  = (r_state == StRun);
  assign busy      = (r_state == StRun) || (r_state == StDrain);
  assign done      = (r_state == StDone);
  assign w_accept  = in_valid && in_ready;
  assign w_start   = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_cnt_inc = r_cnt + CntOne;
  assign w_last    = (w_cnt_inc == r_num);

  assign w_exact = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
  // R may overshoot the exact product, so take the magnitude either way.
  assign w_ed    = (r_exact1 >= r_r1) ? (r_exact1 - r_r1) : (r_r1 - r_exact1);

  assign w_sum_ext = {1'b0, r_sum} + {{(SUM_W + 1 - PW){1'b0}}, r_ed2};
  assign w_sum_sat = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) w_state_next = (num_samples == '0) ? StDone : StRun;
      end
      StRun:   if (w_accept && w_last) w_state_next = StDrain;
      // Final accumulate happens when the last sample leaves stage 2 with stage 1 empty.
      StDrain: if (r_v2 && !r_v1) w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_num   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_num <= num_samples;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a1 <= '0; r_b1 <= '0; r_r1 <= '0; r_exact1 <= '0; r_v1 <= 1'b0;
      r_a2 <= '0; r_b2 <= '0; r_ed2 <= '0; r_v2 <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_a1     <= A;
        r_b1     <= B;
        r_r1     <= R;
        r_exact1 <= w_exact;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_a2  <= r_a1;
        r_b2  <= r_b1;
        r_ed2 <= w_ed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_err   <= '0;
      r_sum   <= '0;
      r_max   <= '0;
      r_max_a <= '0;
      r_max_b <= '0;
    end else if (r_v2) begin
      if (r_ed2 != '0) r_err <= r_err + CntOne;
      r_sum <= w_sum_sat;
      // Strictly greater: ties keep the earlier sample.
      if (r_ed2 > r_max) begin
        r_max   <= r_ed2;
        r_max_a <= r_a2;
        r_max_b <= r_b2;
      end
    end
  end

  assign sample_count = r_cnt;
  assign err_count    = r_err;
  assign sum_ed       = r_sum;
  assign max_ed       = r_max;
  assign max_a        = r_max_a;
  assign max_b        = r_max_b;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed/random bench for approx_mult_err_monitor; expected statistics come from a
// plain-arithmetic model over the queue of samples the bench offers.
module tb_approx_mult_err_monitor;

  localparam int DW = 8;
  localparam int CW = 17;
  localparam int SW = 32;

  logic            clk = 1'b0;
  logic            rst, start, in_valid;
  logic [CW-1:0]   num_samples;
  logic [DW-1:0]   A, B;
  logic [2*DW-1:0] R;
  logic            in_ready, busy, done;
  logic [CW-1:0]   sample_count, err_count;
  logic [SW-1:0]   sum_ed;
  logic [2*DW-1:0] max_ed;
  logic [DW-1:0]   max_a, max_b;

  approx_mult_err_monitor #(.DATA_W(DW), .CNT_W(CW), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .R(R),
    .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
    .sum_ed(sum_ed), .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned qa[$], qb[$], qr[$];
  bit qv[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qr.delete(); qv.delete();
  endtask

  task automatic push(input int unsigned a, input int unsigned b, input int unsigned r);
    qa.push_back(a); qb.push_back(b); qr.push_back(r);
  endtask

  task automatic model(input int n, output longint ec, output longint sm, output longint mx,
                       output longint ma, output longint mb);
    ec = 0; sm = 0; mx = 0; ma = 0; mb = 0;
    for (int i = 0; i < n; i++) begin
      longint ex, rr, ed;
      ex = longint'(qa[i]) * longint'(qb[i]);
      rr = longint'(qr[i]);
      ed = (ex > rr) ? ex - rr : rr - ex;
      if (ed != 0) ec++;
      sm += ed;
      if (sm > 64'd4294967295) sm = 64'd4294967295;
      if (ed > mx) begin
        mx = ed; ma = longint'(qa[i]); mb = longint'(qb[i]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cnt"}, sample_count, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_sum"}, sum_ed, 0);
    chk({tag, "_max"}, max_ed, 0);
    chk({tag, "_max_a"}, max_a, 0);
    chk({tag, "_max_b"}, max_b, 0);
  endtask

  task automatic do_run(input string tag, input int n, input bit extra_start);
    int acc = 0;
    int cyc = 0;
    longint ec, sm, mx, ma, mb;
    num_samples = CW'(n);
    start = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    num_samples = '0;
    check_zero({tag, "_clr"});
    chk({tag, "_done_after_start"}, done, (n == 0));
    chk({tag, "_busy_after_start"}, busy, (n != 0));
    if (n == 0) begin
      chk({tag, "_ready_zero"}, in_ready, 0);
      return;
    end
    while (acc < n) begin
      in_valid = (cyc < qv.size()) ? qv[cyc] : 1'b1;
      A = DW'(qa[acc]);
      B = DW'(qb[acc]);
      R = (2 * DW)'(qr[acc]);
      if (extra_start && cyc == 1) begin
        start = 1'b1;
        num_samples = 1;
      end
      #1;
      chk({tag, "_ready_run"}, in_ready, 1);
      tick();
      start = 1'b0;
      if (in_valid) acc++;
      cyc++;
    end
    in_valid = 1'b1;
    A = DW'($urandom); B = DW'($urandom); R = (2 * DW)'($urandom);
    #1;
    chk({tag, "_ready_after_last"}, in_ready, 0);
    chk({tag, "_done_k1"}, done, 0);
    chk({tag, "_busy_drain"}, busy, 1);
    tick();
    chk({tag, "_done_k2"}, done, 0);
    tick();
    chk({tag, "_done_final"}, done, 1);
    chk({tag, "_busy_final"}, busy, 0);
    model(n, ec, sm, mx, ma, mb);
    chk({tag, "_sample_count"}, sample_count, n);
    chk({tag, "_err_count"}, err_count, ec);
    chk({tag, "_sum_ed"}, sum_ed, sm);
    chk({tag, "_max_ed"}, max_ed, mx);
    chk({tag, "_max_a"}, max_a, ma);
    chk({tag, "_max_b"}, max_b, mb);
    in_valid = 1'b0;
    tick();
    chk({tag, "_done_hold"}, done, 1);
    chk({tag, "_sum_hold"}, sum_ed, sm);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    A = '0; B = '0; R = '0;
    tick(); tick();
    check_zero("reset");
    chk("reset_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    tick();

    // Exact passthrough.
    clear_q();
    for (int i = 0; i < 10; i++) begin
      int unsigned a, b;
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      push(a, b, a * b);
    end
    do_run("pass", 10, 1'b0);
    chk("pass_err_zero", err_count, 0);

    // Single error.
    clear_q();
    push(15, 15, 200);
    do_run("single", 1, 1'b0);
    chk("single_sum_25", sum_ed, 25);

    // Overshoot and tie.
    clear_q();
    push(2, 3, 10); push(4, 4, 9); push(1, 9, 2);
    do_run("tie", 3, 1'b0);
    chk("tie_sum_18", sum_ed, 18);
    chk("tie_max_a_4", max_a, 4);

    // Handshake with gaps, surplus valid and an ignored start during RUN.
    clear_q();
    for (int i = 0; i < 4; i++) push($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 65535));
    qv.push_back(1); qv.push_back(0); qv.push_back(1);
    qv.push_back(1); qv.push_back(0); qv.push_back(1);
    do_run("hs", 4, 1'b1);

    // num_samples == 0 goes straight to DONE with zeroed results.
    do_run("zero", 0, 1'b0);

    // Reset mid-run after 3 of 8 samples.
    clear_q();
    for (int i = 0; i < 8; i++) push($urandom_range(1, 255), $urandom_range(1, 255), 0);
    num_samples = 8; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = DW'(qa[i]); B = DW'(qb[i]); R = '0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero("rstmid");
    chk("rstmid_ready", in_ready, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    tick();
    chk("rstmid_sum_after", sum_ed, 0);
    chk("rstmid_cnt_after", sample_count, 0);
    do_run("restart", 8, 1'b0);

    // Exhaustive sweep with R = 0.
    clear_q();
    for (int i = 0; i < 65536; i++) push(i >> 8, i & 255, 0);
    do_run("sweep", 65536, 1'b0);
    chk("sweep_cnt_const", sample_count, 65536);
    chk("sweep_max_const", max_ed, 65025);
    chk("sweep_sum_const", sum_ed, 1065369600);
    chk("sweep_err_const", err_count, 65025);
    chk("sweep_ma_const", max_a, 255);
    chk("sweep_mb_const", max_b, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
